fx_bc_s: RTL
============

// Module: fx_bc_s
// PURPOSE
// - Slave endpoint of the fx parallel bus, on the far side from the master bus controller.
// - Decodes fx writes and reads addressed to this module's ID.
// - Holds a RW config register bank and exposes sampled RO status registers.
// - Keeps a sticky, read-to-clear interrupt-pending register and drives a level IRQ back to the master side.
// - fx_q is zero when not selected, so several slaves can be OR-combined onto one master fx_q.
// PARAMETERS
// - MOD_ID    8'h01   match value for addr[15:8], for both fx_waddr and fx_raddr
// - NREG      16      number of RW config regs at addr[7:0] = 0x00..NREG-1 (1..128)
// - NSTS      8       number of RO status regs at addr[7:0] = 0x80..0x80+NSTS-1 (1..64)
// - CFG_RST   8'h00   reset value of every config reg
// PORTS
// - clk_sys     in   1        system clock, all logic on rising edge
// - rst         in   1        asynchronous reset, active-high
// - fx_waddr    in   16       write address: [15:8] module, [7:0] register
// - fx_wr       in   1        write strobe, one clk_sys cycle per write
// - fx_data     in   8        write data, qualified by fx_wr
// - fx_rd       in   1        read strobe, one clk_sys cycle per read
// - fx_raddr    in   16       read address, qualified by fx_rd
// - fx_q        out  8        read data, registered
// - cfg_flat    out  NREG*8   config regs, reg i at [8i+7:8i]
// - cfg_stb     out  NREG     one-hot pulse, one cycle, marks which config reg was just written
// - sts_flat    in   NSTS*8   status inputs, reg j at [8j+7:8j]
// - irq_src     in   8        event pulses, one per pending bit
// - irq_en_out  out  8        mirror of IRQ enable reg
// - irq_out     out  1        |(pending & enable), registered
// BEHAVIOUR
// - Reset values: fx_q=0, cfg regs=CFG_RST, cfg_stb=0, pending=0, enable=0, irq_out=0, status snapshot=0.
// - Write decode, when fx_wr=1 and fx_waddr[15:8]=MOD_ID:
//   - addr<NREG: the cfg reg takes fx_data at the next edge; that cfg_stb bit pulses in the same cycle the new value appears.
//   - 0xF1: writes the enable reg.
//   - 0xF0: write-1-to-clear pending bits.
//   - Any other address: ignored, no strobe.
// - Status snapshot: sts_flat is registered every cycle into the snapshot.
//   - Reads return the snapshot, so status read latency is input->snapshot->fx_q.
// - Read, when fx_rd=1 and fx_raddr[15:8]=MOD_ID:
//   - fx_q is updated at the next edge: 1-cycle latency.
//   - fx_q holds that value until the next fx_rd cycle.
// - Read map: cfg regs; status at 0x80+j; 0xF0 pending; 0xF1 enable; 0xFE = MOD_ID; 0xFF = 8'hA5 (signature). Unmapped or out-of-range addresses return 8'h00.
// - fx_rd with a non-matching module ID: fx_q <= 0 at the next edge.
// - fx_q is cleared to 0 on the cycle after any read cycle only if a non-matching read occurs; it is otherwise held.
// - Reading 0xF0 returns the current pending bits, then clears them (read-to-clear).
// - Pending update, each cycle: pending <= (pending & ~clr) | irq_src.
//   - clr is the read-clear mask or the W1C mask.
//   - A new event wins over a clear in the same cycle, so the bit stays 1.
// - irq_out = |(pending & enable), registered one cycle after pending changes.
// - fx_wr and fx_rd in the same cycle to the same address:
//   - The read returns the old value.
//   - The write takes effect at the same edge.
// - fx_wr and fx_rd in the same cycle to different addresses: both are serviced independently.
// - Reset asserted mid-transfer: all state returns to reset values at once; the strobe in flight is lost.
// - No wait states: the master may issue back-to-back strobes every cycle.
// STRUCTURE
// - Shared package fx_pkg holds:
//   - address constants ADDR_STS_BASE=8'h80, ADDR_IRQ_PEND=8'hF0, ADDR_IRQ_EN=8'hF1, ADDR_ID=8'hFE, ADDR_SIG=8'hFF
//   - SIG_VALUE=8'hA5
//   - the fx address field widths (module [15:8], register [7:0]), also used by fx_bc_m.
// - One sub-module, fx_irq_pend: the pending/enable/W1C/read-clear logic and the irq_out register.
// - The top-level module holds address decode, the cfg bank, the status snapshot and the fx_q mux/register.
// TESTING
// - Write 0x5A to 0x0103 (MOD_ID=01):
//   - cfg reg 3 = 0x5A; cfg_stb = 16'h0008 for exactly 1 cycle.
//   - Read 0x0103: fx_q = 0x5A one cycle after fx_rd.
// - Write 0x77 to 0x0203 (wrong module): no cfg change, no strobe. Read 0x0203: fx_q = 0x00.
// - Status read:
//   - Drive sts reg 2 = 0xC3, wait 2 cycles, read 0x0182 -> 0xC3.
//   - Read 0x01FE -> 0x01; read 0x01FF -> 0xA5; read 0x0190 (NSTS=8) -> 0x00.
// - IRQ sequence:
//   - Write 0x01F1 = 0x05, then pulse irq_src = 0x04 -> irq_out=1 two cycles later.
//   - Read 0x01F0 -> 0x04; pending clears; irq_out falls.
// - Pulse irq_src = 0x01 in the same cycle as a read of 0x01F0:
//   - The read returns the old pending value.
//   - Bit0 remains set afterwards.
//   - A W1C write of 0x01 with a simultaneous event gives the same result (bit stays set).
// - Same-cycle write of 0x33 and read of addr 0x0100 (old 0x11):
//   - fx_q = 0x11; a later read returns 0x33.
//   - Assert rst mid-sequence: all outputs read 0 and cfg regs = CFG_RST.

Source files
------------

// File: rtl/fx_pkg.sv
// Shared fx bus definitions: address field layout, fixed register addresses
// and the signature constant used by both bus controller endpoints.
package fx_pkg;
  localparam int MOD_W  = 8;
  localparam int REG_W  = 8;
  localparam int ADDR_W = MOD_W + REG_W;

  localparam logic [7:0] ADDR_STS_BASE = 8'h80;
  localparam logic [7:0] ADDR_IRQ_PEND = 8'hF0;
  localparam logic [7:0] ADDR_IRQ_EN   = 8'hF1;
  localparam logic [7:0] ADDR_ID       = 8'hFE;
  localparam logic [7:0] ADDR_SIG      = 8'hFF;
  localparam logic [7:0] SIG_VALUE     = 8'hA5;

  typedef struct packed {
    logic [MOD_W-1:0] mod;
    logic [REG_W-1:0] rg;
  } fx_addr_t;

  function automatic logic fx_hit(input fx_addr_t a, input logic [MOD_W-1:0] id);
    return a.mod == id;
  endfunction
endpackage

// File: rtl/fx_irq_pend.sv
// Sticky interrupt-pending bits with enable mask, W1C/read-clear and a
// registered level IRQ.
module fx_irq_pend
  import fx_pkg::*;
(
  input  logic       clk_sys,
  input  logic       rst,
  input  logic [7:0] irq_src,
  input  logic       en_we,
  input  logic       w1c_we,
  input  logic [7:0] wdata,
  input  logic       rd_clr,
  output logic [7:0] pend,
  output logic [7:0] en,
  output logic       irq_out
);
  logic [7:0] clr;

  always_comb begin
    clr = 8'h00;
    if (w1c_we) clr = clr | wdata;
    if (rd_clr) clr = clr | pend;
  end

  // irq_src is OR-ed in after the clear so a same-cycle event is never lost
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      pend    <= 8'h00;
      en      <= 8'h00;
      irq_out <= 1'b0;
    end else begin
      if (en_we) en <= wdata;
      pend    <= (pend & ~clr) | irq_src;
      irq_out <= |(pend & en);
    end
  end
endmodule

// File: rtl/fx_bc_s.sv
// fx bus slave endpoint: address decode, RW config bank, sampled status
// snapshot, interrupt block and the registered fx_q read port.
module fx_bc_s
  import fx_pkg::*;
#(
  parameter logic [7:0] MOD_ID  = 8'h01,
  parameter int         NREG    = 16,
  parameter int         NSTS    = 8,
  parameter logic [7:0] CFG_RST = 8'h00
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   fx_waddr,
  input  logic                fx_wr,
  input  logic [7:0]          fx_data,
  input  logic                fx_rd,
  input  logic [ADDR_W-1:0]   fx_raddr,
  output logic [7:0]          fx_q,
  output logic [NREG*8-1:0]   cfg_flat,
  output logic [NREG-1:0]     cfg_stb,
  input  logic [NSTS*8-1:0]   sts_flat,
  input  logic [7:0]          irq_src,
  output logic [7:0]          irq_en_out,
  output logic                irq_out
);
  fx_addr_t wa, ra;
  logic     wsel, rsel;
  logic [NREG-1:0][7:0] cfg;
  logic [NSTS-1:0][7:0] snap;
  logic [NREG-1:0]      stb_nxt;
  logic [7:0]           rdata, pend, en;

  assign wa   = fx_addr_t'(fx_waddr);
  assign ra   = fx_addr_t'(fx_raddr);
  assign wsel = fx_wr && fx_hit(wa, MOD_ID);
  assign rsel = fx_rd && fx_hit(ra, MOD_ID);

  always_comb begin
    stb_nxt = '0;
    for (int i = 0; i < NREG; i++)
      if (wsel && wa.rg == 8'(i)) stb_nxt[i] = 1'b1;
  end

  // Read mux sees pre-edge state, so a same-cycle write returns the old value
  always_comb begin
    rdata = 8'h00;
    for (int i = 0; i < NREG; i++)
      if (ra.rg == 8'(i)) rdata = cfg[i];
    for (int j = 0; j < NSTS; j++)
      if (ra.rg == ADDR_STS_BASE + 8'(j)) rdata = snap[j];
    case (ra.rg)
      ADDR_IRQ_PEND: rdata = pend;
      ADDR_IRQ_EN:   rdata = en;
      ADDR_ID:       rdata = MOD_ID;
      ADDR_SIG:      rdata = SIG_VALUE;
      default:       ;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cfg     <= {NREG{CFG_RST}};
      cfg_stb <= '0;
      snap    <= '0;
      fx_q    <= 8'h00;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (stb_nxt[i]) cfg[i] <= fx_data;
      cfg_stb <= stb_nxt;
      snap    <= sts_flat;
      if (fx_rd) fx_q <= rsel ? rdata : 8'h00;
    end
  end

  fx_irq_pend u_irq (
    .clk_sys (clk_sys),
    .rst     (rst),
    .irq_src (irq_src),
    .en_we   (wsel && wa.rg == ADDR_IRQ_EN),
    .w1c_we  (wsel && wa.rg == ADDR_IRQ_PEND),
    .wdata   (fx_data),
    .rd_clr  (rsel && ra.rg == ADDR_IRQ_PEND),
    .pend    (pend),
    .en      (en),
    .irq_out (irq_out)
  );

  assign cfg_flat   = cfg;
  assign irq_en_out = en;
endmodule
